// File: rtl/cla_seq_adder32_pkg.sv
// Shared ALU definitions for the MIPS_Archi datapath.
//   WIDTH / SLICE : operand width and width of the shared carry-lookahead slice
//   state_t       : sequencer state encoding
//   ADD / SUB     : ALU op bit (0 = A+B, 1 = A-B)
package cla_seq_adder32_pkg;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/cla_seq_adder32_cla8.sv
// CLA_8bit: 8-bit carry-lookahead adder slice.
//   A, B : 8-bit operands
//   Cin  : carry in
//   S    : 8-bit sum
//   Cout : carry out of bit 7
// Each carry is built from the flattened generate/propagate products rather
// than rippling, so every carry is a two-level function of g, p and Cin.
module CLA_8bit (
  output logic [7:0] S,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    logic acc;
    logic prop;
    c    = '0;
    c[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & Cin);
    end
  end

  assign S    = p ^ c[7:0];
  assign Cout = c[8];

endmodule

// File: rtl/cla_seq_adder32.sv
// Multi-cycle add/subtract sequencer. One shared 8-bit CLA slice is stepped
// across the operand bytes, least-significant first, with the inter-slice
// carry held in a register between steps.
//   clk, rst        : clock (rising edge), async active-high reset
//   start, sub, a, b: request and operands, sampled when busy=0
//   busy            : slices being computed
//   done            : one-cycle pulse, result valid
//   sum, cout       : result and carry out of the MSB (sub: 1 = no borrow)
//   overflow, zero  : signed overflow, sum == 0
//
// state | meaning
// IDLE  | waiting for start, last result held
// RUN   | one slice per cycle, idx selects the byte
// DONE  | result valid for one cycle; start here is accepted back-to-back
module cla_seq_adder32
  import cla_seq_adder32_pkg::*;
#(
  parameter int WIDTH = cla_seq_adder32_pkg::WIDTH,
  parameter int SLICE = cla_seq_adder32_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be a multiple of SLICE, and SLICE must stay 8 to match CLA_8bit.
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [IDXW-1:0]    idx;
  logic               carry_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_s;
  logic               slice_c;
  logic [WIDTH-1:0]   sum_merged;
  logic               last;
  logic               accept;

  assign last   = (idx == IDXW'(NSLICE - 1));
  assign accept = start && (state != RUN);

  assign slice_a = op_a[int'(idx)*SLICE +: SLICE];
  assign slice_b = op_b[int'(idx)*SLICE +: SLICE];

  CLA_8bit u_cla (
    .S    (slice_s),
    .Cout (slice_c),
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_q)
  );

  // Completed result as it will look after the final slice is written,
  // so zero is valid in the same edge as the last byte.
  always_comb begin
    sum_merged                    = sum;
    sum_merged[WIDTH-1 -: SLICE]  = slice_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry_q  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
      op_a     <= a;
      op_b     <= (sub == SUB) ? ~b : b;
      carry_q  <= sub;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (state == RUN) begin
      sum[int'(idx)*SLICE +: SLICE] <= slice_s;
      carry_q                       <= slice_c;
      idx                           <= idx + 1'b1;
      if (last) begin
        cout     <= slice_c;
        overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (slice_s[SLICE-1] != op_a[WIDTH-1]);
        zero     <= (sum_merged == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder32.sv
module tb_cla_seq_adder32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  cla_seq_adder32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Reference: plain 33-bit arithmetic and the textbook signed-overflow rules.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    exp_t        e;
    logic [32:0] r;
    if (!ms) begin
      r      = {1'b0, ma} + {1'b0, mb};
      e.cout = r[32];
      e.ovf  = (ma[31] == mb[31]) && (r[31] != ma[31]);
    end else begin
      r      = {1'b0, ma} - {1'b0, mb};
      e.cout = (ma >= mb);
      e.ovf  = (ma[31] != mb[31]) && (r[31] != ma[31]);
    end
    e.sum  = r[31:0];
    e.zero = (r[31:0] == 32'd0);
    e.due  = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, output bit acc);
    exp_t e;
    start = 1'b1;
    a     = ta;
    b     = tb_;
    sub   = ts;
    acc   = !busy;
    if (acc) begin
      e     = model(ta, tb_, ts);
      e.due = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout, got done=0 expected done=1");
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    bit acc;
    issue(ta, tb_, ts, acc);
    check("accept", 32'(acc), 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  exp_t mon_e;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected no done");
        end else begin
          mon_e = sb.pop_front();
          check("sum",      sum,        mon_e.sum);
          check("cout",     32'(cout),  32'(mon_e.cout));
          check("overflow", 32'(overflow), 32'(mon_e.ovf));
          check("zero",     32'(zero),  32'(mon_e.zero));
          check("latency",  32'(cyc),   32'(mon_e.due));
          check("busy_at_done", 32'(busy), 32'd0);
        end
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_pulse: got done high 2 cycles expected 1");
        end
      end
    end
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit acc2;

    #1 rst = 1'b1;
    #11;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  sum, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simple add, then result must stay held in IDLE.
    issue(32'h0000_00A5, 32'h0000_005A, 1'b0, acc);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_sum",  sum, 32'h0000_00FF);
    check("hold_done", 32'(done), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1);

    // Start while busy is ignored; start in DONE is accepted back-to-back.
    issue(32'h0000_0010, 32'h0000_0001, 1'b0, acc);
    issue(32'h0000_00F1, 32'h0000_001F, 1'b0, acc2);
    check("busy_start_ignored", 32'(acc2), 32'd0);
    wait_done();
    issue(32'h0000_0100, 32'h0000_0200, 1'b0, acc);
    check("b2b_accept", 32'(acc), 32'd1);
    check("b2b_busy",   32'(busy), 32'd1);
    wait_done();
    @(negedge clk);

    // Async reset after two slices.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("partial_sum", sum, 32'h0000_3333);
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum",  sum, 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h0000_00E2, 32'h0000_002E, 1'b0);

    // Randomized traffic with gaps, back-to-back starts and ignored starts.
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      issue(pick(), pick(), 1'($urandom_range(0, 1)), acc);
      check("rand_accept", 32'(acc), 32'd1);
      if ($urandom_range(0, 3) == 0) begin
        issue($urandom, $urandom, 1'($urandom_range(0, 1)), acc2);
        check("rand_ignored", 32'(acc2), 32'd0);
      end
      wait_done();
      if (gap > 0) repeat (gap) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
